// File: rtl/player_select_ctrl_pkg.sv
// Shared types and constants for the two-player switch selection front end.
// Holds the FSM encoding and the one-hot group decoder used by the top level.
package player_select_ctrl_pkg;

   typedef enum logic [1:0] {
      SEL     = 2'd0,
      SHOW    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [2:0] CODE_NONE = 3'd0;
   localparam int         GROUP_W   = 5;

   typedef struct packed {
      logic       multi;
      logic [2:0] code;
   } group_dec_t;

   // The group MSB maps to code 1; two or more bits set reports multi with no code.
   function automatic group_dec_t decode_group(input logic [GROUP_W-1:0] bits);
      group_dec_t  d;
      int unsigned ones;
      d.multi = 1'b0;
      d.code  = CODE_NONE;
      ones    = 0;
      for (int i = 0; i < GROUP_W; i++) begin
         if (bits[i]) begin
            ones++;
            d.code = 3'(GROUP_W - i);
         end
      end
      if (ones > 1) begin
         d.multi = 1'b1;
         d.code  = CODE_NONE;
      end
      return d;
   endfunction

endpackage

// File: rtl/player_select_ctrl_if.sv
// Switch inputs and locked player outputs of the selection front end.
// The master side drives the switches; the slave side is the controller.
interface player_select_ctrl_if;
   logic       D9, D8, D7, D6, D5, D4, D3, D2, D1, D0;
   logic [4:0] value_player1;
   logic [4:0] value_player2;
   logic       both_valid;
   logic       err_multi;

   modport master (
      output D9, D8, D7, D6, D5, D4, D3, D2, D1, D0,
      input  value_player1, value_player2, both_valid, err_multi
   );

   modport slave (
      input  D9, D8, D7, D6, D5, D4, D3, D2, D1, D0,
      output value_player1, value_player2, both_valid, err_multi
   );
endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a stability counter for one raw switch.
// The clean output follows the synced input only after DB_CYCLES stable cycles.
module switch_debounce #(
   parameter int DB_CYCLES = 1_000_000,
   parameter int CNT_W     = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         clean <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == clean) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            // Counter parks at its maximum; it clears next cycle once clean matches.
            clean <= sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/player_select_ctrl.sv
// Debounces ten slide switches, locks one choice per player, then shows both
// locked values for HOLD_CYCLES before waiting for every switch to be released.
module player_select_ctrl
   import player_select_ctrl_pkg::*;
#(
   parameter int DB_CYCLES   = 1_000_000,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input logic                 clk,
   input logic                 rst,
   player_select_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

   logic [9:0] raw;
   logic [9:0] clean;

   assign raw = {bus.D9, bus.D8, bus.D7, bus.D6, bus.D5,
                 bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};

   for (genvar i = 0; i < 10; i++) begin : g_db
      switch_debounce #(
         .DB_CYCLES(DB_CYCLES),
         .CNT_W    (CNT_W)
      ) u_db (
         .clk  (clk),
         .rst  (rst),
         .raw  (raw[i]),
         .clean(clean[i])
      );
   end

   group_dec_t dec1;
   group_dec_t dec2;

   assign dec1 = decode_group(clean[9:5]);
   assign dec2 = decode_group(clean[4:0]);

   state_t           state, state_next;
   logic [2:0]       code1, code1_next;
   logic [2:0]       code2, code2_next;
   logic [CNT_W-1:0] hold_cnt, hold_next;
   logic             show_q, show_next;
   logic             err_q, err_next;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= SEL;
         code1    <= CODE_NONE;
         code2    <= CODE_NONE;
         hold_cnt <= '0;
         show_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_next;
         code1    <= code1_next;
         code2    <= code2_next;
         hold_cnt <= hold_next;
         show_q   <= show_next;
         err_q    <= err_next;
      end
   end

   // NOTE: every signal gets a default first so no path through the case leaves a latch.
   always_comb begin
      state_next = state;
      code1_next = code1;
      code2_next = code2;
      hold_next  = hold_cnt;
      show_next  = show_q;
      err_next   = err_q;
      unique case (state)
         SEL: begin
            // A register loads only while still empty, so later switch moves are ignored.
            if (code1 == CODE_NONE && !dec1.multi) code1_next = dec1.code;
            if (code2 == CODE_NONE && !dec2.multi) code2_next = dec2.code;
            if (dec1.multi || dec2.multi) err_next = 1'b1;
            if (code1 != CODE_NONE && code2 != CODE_NONE) begin
               state_next = SHOW;
               hold_next  = '0;
               show_next  = 1'b1;
            end
         end
         SHOW: begin
            if (hold_cnt == HOLD_MAX) begin
               state_next = RELEASE;
               show_next  = 1'b0;
            end else begin
               hold_next = hold_cnt + CNT_W'(1);
            end
         end
         RELEASE: begin
            if (clean == '0) begin
               state_next = SEL;
               code1_next = CODE_NONE;
               code2_next = CODE_NONE;
               err_next   = 1'b0;
            end
         end
         default: begin
            state_next = SEL;
            show_next  = 1'b0;
         end
      endcase
   end

   assign bus.value_player1 = {2'b00, code1};
   assign bus.value_player2 = {2'b00, code2};
   assign bus.both_valid    = show_q;
   assign bus.err_multi     = err_q;

endmodule
